// File: rtl/tl45_pipe_ctrl.sv
// Pipeline control for the tl45 core: turns load-use hazards, memory back-pressure,
// taken control transfers and decode errors into fetch/decode stall, flush and execute-bubble controls.
module tl45_pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_dec_valid,
  input  logic [3:0]  i_dec_sr1,
  input  logic [3:0]  i_dec_sr2,
  input  logic        i_ex_valid,
  input  logic [4:0]  i_ex_opcode,
  input  logic [3:0]  i_ex_dr,
  input  logic        i_mem_busy,
  input  logic        i_br_taken,
  input  logic        i_decode_err,
  input  logic [31:0] i_dec_pc,
  output logic        o_stall_fetch,
  output logic        o_stall_decode,
  output logic        o_flush_decode,
  output logic        o_bubble_ex,
  output logic        o_halted,
  output logic [31:0] o_err_pc,
  output logic [15:0] o_stall_count,
  output logic [1:0]  o_dbg_state
);

  // Handshake note: this block has no valid/ready pairs of its own; stalls are
  // level signals meaning "hold your register this cycle", flush means "load empty".

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [4:0] OP_LW        = 5'h14;
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] err_pc_q, err_pc_d;
  logic [15:0] stall_cnt_q;

  logic load_use;
  logic stall_fetch, stall_decode, flush_decode, bubble_ex, halted;

  assign load_use = i_ex_valid && (i_ex_opcode == OP_LW) && (i_ex_dr != 4'd0) &&
                    i_dec_valid && ((i_ex_dr == i_dec_sr1) || (i_ex_dr == i_dec_sr2));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_RUN;
      cnt_q    <= 4'd0;
      err_pc_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_pc_q <= err_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_pc_d     = err_pc_q;
    stall_fetch  = 1'b0;
    stall_decode = 1'b0;
    flush_decode = 1'b0;
    bubble_ex    = 1'b0;
    halted       = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (i_br_taken) begin
          flush_decode = 1'b1;
          if (MULTI_FLUSH) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end
        end else if (i_decode_err) begin
          state_d      = ST_HALT;
          err_pc_d     = i_dec_pc;
          stall_fetch  = 1'b1;
          stall_decode = 1'b1;
        end else if (i_mem_busy) begin
          // Execute holds as well, so no bubble is inserted under back-pressure.
          stall_fetch  = 1'b1;
          stall_decode = 1'b1;
        end else if (load_use) begin
          stall_fetch  = 1'b1;
          stall_decode = 1'b1;
          bubble_ex    = 1'b1;
        end
      end
      ST_FLUSH: begin
        // Wrong-path decode errors are dropped while flushing.
        flush_decode = 1'b1;
        if (i_br_taken) begin
          cnt_d = FLUSH_RELOAD;
        end else if (!i_mem_busy) begin
          if (cnt_q <= 4'd1) begin
            state_d = ST_RUN;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      ST_HALT: begin
        halted       = 1'b1;
        stall_fetch  = 1'b1;
        stall_decode = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs are forced low for as long as reset is held, independent of inputs.
  assign o_stall_fetch  = i_reset_n & stall_fetch;
  assign o_stall_decode = i_reset_n & stall_decode;
  assign o_flush_decode = i_reset_n & flush_decode;
  assign o_bubble_ex    = i_reset_n & bubble_ex;
  assign o_halted       = i_reset_n & halted;
  assign o_err_pc       = err_pc_q;
  assign o_stall_count  = stall_cnt_q;
  assign o_dbg_state    = state_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stall_cnt_q <= 16'd0;
    end else if (o_stall_decode && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_tl45_pipe_ctrl.sv
// Bench for tl45_pipe_ctrl: directed vectors with literal checks plus a per-cycle
// comparison against a flush-countdown / halt-flag model of the control rules.
module tb_tl45_pipe_ctrl;

  localparam int FC = 2;

  logic        clk;
  logic        rst_n;
  logic        dec_valid;
  logic [3:0]  dec_sr1, dec_sr2;
  logic        ex_valid;
  logic [4:0]  ex_opcode;
  logic [3:0]  ex_dr;
  logic        mem_busy, br_taken, decode_err;
  logic [31:0] dec_pc;
  logic        stall_fetch, stall_decode, flush_decode, bubble_ex, halted;
  logic [31:0] err_pc;
  logic [15:0] stall_count;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  tl45_pipe_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_dec_valid    (dec_valid),
    .i_dec_sr1      (dec_sr1),
    .i_dec_sr2      (dec_sr2),
    .i_ex_valid     (ex_valid),
    .i_ex_opcode    (ex_opcode),
    .i_ex_dr        (ex_dr),
    .i_mem_busy     (mem_busy),
    .i_br_taken     (br_taken),
    .i_decode_err   (decode_err),
    .i_dec_pc       (dec_pc),
    .o_stall_fetch  (stall_fetch),
    .o_stall_decode (stall_decode),
    .o_flush_decode (flush_decode),
    .o_bubble_ex    (bubble_ex),
    .o_halted       (halted),
    .o_err_pc       (err_pc),
    .o_stall_count  (stall_count),
    .o_dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  bit          m_halted;
  int          m_flush_left;   // flush cycles still owed after the current one
  logic [31:0] m_err_pc;
  int          m_stall_cnt;

  function automatic logic [52:0] model_expect();
    logic sf, sd, fl, bx, h, lu;
    sf = 0; sd = 0; fl = 0; bx = 0; h = 0;
    lu = ex_valid && ex_opcode == 5'h14 && ex_dr != 0 && dec_valid &&
         (ex_dr == dec_sr1 || ex_dr == dec_sr2);
    if (rst_n) begin
      if (m_halted) begin
        h = 1; sf = 1; sd = 1;
      end else if (m_flush_left > 0) begin
        fl = 1;
      end else if (br_taken) begin
        fl = 1;
      end else if (decode_err || mem_busy) begin
        sf = 1; sd = 1;
      end else if (lu) begin
        sf = 1; sd = 1; bx = 1;
      end
    end
    return {sf, sd, fl, bx, h, m_err_pc, 16'(m_stall_cnt)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [52:0] e;
    if (!rst_n) begin
      m_halted     <= 0;
      m_flush_left <= 0;
      m_err_pc     <= 32'd0;
      m_stall_cnt  <= 0;
    end else begin
      e = model_expect();
      if (m_halted) begin
      end else if (m_flush_left > 0) begin
        if (br_taken)       m_flush_left <= FC - 1;
        else if (!mem_busy) m_flush_left <= m_flush_left - 1;
      end else if (br_taken) begin
        m_flush_left <= FC - 1;
      end else if (decode_err) begin
        m_halted <= 1;
        m_err_pc <= dec_pc;
      end
      if (e[51] && m_stall_cnt < 65535) m_stall_cnt <= m_stall_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [52:0] exp_q[$];

  always @(negedge clk) begin
    logic [52:0] act, e;
    exp_q.push_back(model_expect());
    act = {stall_fetch, stall_decode, flush_decode, bubble_ex, halted, err_pc, stall_count};
    e = exp_q.pop_front();
    n_cmp++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, act, e);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    dec_valid = 0; dec_sr1 = 0; dec_sr2 = 0;
    ex_valid = 0; ex_opcode = 0; ex_dr = 0;
    mem_busy = 0; br_taken = 0; decode_err = 0; dec_pc = 0;
  endtask

  task automatic set_lu(input logic [3:0] dr, input logic [3:0] s1, input logic [3:0] s2);
    ex_valid = 1; ex_opcode = 5'h14; ex_dr = dr;
    dec_valid = 1; dec_sr1 = s1; dec_sr2 = s2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 0;
    #2 rst_n = 1;
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    rst_n = 0;
    set_lu(4'd3, 4'd3, 4'd0);
    #2;
    chk("reset_stall_fetch", 32'(stall_fetch), 0);
    chk("reset_bubble", 32'(bubble_ex), 0);
    @(negedge clk);
    #1 rst_n = 1;
    idle();
    tick();
    chk("reset_count", 32'(stall_count), 0);
    chk("reset_err_pc", err_pc, 0);

    // load-use on sr1, then cleared
    set_lu(4'd3, 4'd3, 4'd0);
    at_neg();
    chk("lu_stall_fetch", 32'(stall_fetch), 1);
    chk("lu_stall_decode", 32'(stall_decode), 1);
    chk("lu_bubble", 32'(bubble_ex), 1);
    tick();
    ex_opcode = 5'h00;
    at_neg();
    chk("lu_clear_stall", 32'(stall_decode), 0);
    tick();
    chk("lu_count", 32'(stall_count), 1);
    set_lu(4'd0, 4'd0, 4'd0);
    at_neg();
    chk("lu_r0_stall", 32'(stall_fetch), 0);
    tick();
    set_lu(4'd5, 4'd1, 4'd5);
    at_neg();
    chk("lu_sr2_bubble", 32'(bubble_ex), 1);
    tick();
    idle();

    // load-use under back-pressure
    do_reset();
    chk("rst2_count", 32'(stall_count), 0);
    set_lu(4'd7, 4'd7, 4'd0);
    mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("busy_stall", 32'(stall_decode), 1);
      chk("busy_no_bubble", 32'(bubble_ex), 0);
      tick();
    end
    mem_busy = 0;
    at_neg();
    chk("busy_then_bubble", 32'(bubble_ex), 1);
    tick();
    idle();
    at_neg();
    chk("busy_after_stall", 32'(stall_decode), 0);
    chk("busy_count", 32'(stall_count), 4);
    tick();

    // single branch: flush two cycles
    br_taken = 1;
    at_neg();
    chk("br_flush0", 32'(flush_decode), 1);
    chk("br_no_stall", 32'(stall_fetch), 0);
    tick();
    br_taken = 0;
    at_neg();
    chk("br_flush1", 32'(flush_decode), 1);
    tick();
    at_neg();
    chk("br_flush_done", 32'(flush_decode), 0);
    tick();

    // back-to-back branches
    br_taken = 1;
    tick();
    at_neg();
    chk("br2_flush1", 32'(flush_decode), 1);
    tick();
    br_taken = 0;
    at_neg();
    chk("br2_flush2", 32'(flush_decode), 1);
    tick();
    at_neg();
    chk("br2_done", 32'(flush_decode), 0);
    tick();

    // branch with memory back-pressure during flush
    br_taken = 1;
    tick();
    br_taken = 0;
    mem_busy = 1;
    at_neg();
    chk("brbusy_flush", 32'(flush_decode), 1);
    chk("brbusy_no_stall", 32'(stall_fetch), 0);
    tick();
    tick();
    mem_busy = 0;
    at_neg();
    chk("brbusy_flush_last", 32'(flush_decode), 1);
    tick();
    at_neg();
    chk("brbusy_done", 32'(flush_decode), 0);
    tick();

    // decode error on the wrong path
    br_taken = 1;
    tick();
    br_taken = 0;
    decode_err = 1;
    dec_pc = 32'h80;
    at_neg();
    chk("err_in_flush_flush", 32'(flush_decode), 1);
    tick();
    decode_err = 0;
    at_neg();
    chk("err_in_flush_nohalt", 32'(halted), 0);
    tick();

    // decode error coincident with branch
    br_taken = 1;
    decode_err = 1;
    at_neg();
    chk("coinc_flush", 32'(flush_decode), 1);
    chk("coinc_no_stall", 32'(stall_decode), 0);
    tick();
    br_taken = 0;
    decode_err = 0;
    at_neg();
    chk("coinc_nohalt", 32'(halted), 0);
    tick();
    tick();

    // real decode error: halt
    decode_err = 1;
    dec_pc = 32'h0000_0040;
    at_neg();
    chk("err_stall_now", 32'(stall_fetch), 1);
    chk("err_not_halted_yet", 32'(halted), 0);
    tick();
    decode_err = 0;
    br_taken = 1;
    set_lu(4'd2, 4'd2, 4'd0);
    at_neg();
    chk("halt_flag", 32'(halted), 1);
    chk("halt_err_pc", err_pc, 32'h40);
    chk("halt_no_flush", 32'(flush_decode), 0);
    chk("halt_no_bubble", 32'(bubble_ex), 0);
    chk("halt_stall", 32'(stall_decode), 1);
    tick();
    idle();
    repeat (65600) tick();
    chk("count_saturated", 32'(stall_count), 32'hFFFF);

    // asynchronous reset in the middle of a cycle
    set_lu(4'd4, 4'd4, 4'd0);
    mem_busy = 1;
    #2 rst_n = 0;
    #1;
    chk("areset_halted", 32'(halted), 0);
    chk("areset_stall", 32'(stall_fetch), 0);
    chk("areset_err_pc", err_pc, 0);
    chk("areset_count", 32'(stall_count), 0);
    @(negedge clk);
    #1 rst_n = 1;
    idle();
    tick();
    at_neg();
    chk("after_reset_run", 32'(halted), 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tl45_pipe_ctrl.md
# tl45_pipe_ctrl

Pipeline control unit for the tl45 core. It sequences the fetch and decode stages by generating stall, flush and execute-bubble controls. The triggers are load-use hazards, memory back-pressure, taken control transfers and decode errors. It sits beside the decode stage: its stall/flush outputs drive the decode stage's stall/flush inputs, and its error outputs latch the faulting PC and halt the core.

## Interface
Parameters:
- FLUSH_CYCLES, 2, number of cycles the decode flush is held after a taken branch (legal range 1..15)

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_reset_n  in  1  reset; asynchronous assert, active-low, synchronous deassert externally guaranteed
- i_dec_valid  in  1  decode output buffer holds a real instruction
- i_dec_sr1  in  4  sr1 of instruction in decode output buffer
- i_dec_sr2  in  4  sr2 of instruction in decode output buffer (already remapped: SW data reg, SP for CALL/RET, 0 for immediate forms)
- i_ex_valid  in  1  execute stage holds a real instruction
- i_ex_opcode  in  5  opcode in execute
- i_ex_dr  in  4  destination register in execute
- i_mem_busy  in  1  memory stage cannot accept this cycle
- i_br_taken  in  1  one-cycle pulse: execute resolved a taken JMP/CALL/RET/branch
- i_decode_err  in  1  registered decode error flag from decode stage
- i_dec_pc  in  32  PC in decode output buffer (faulting PC when i_decode_err=1)
- o_stall_fetch  out  1  hold fetch and PC
- o_stall_decode  out  1  hold decode (drives decode i_pipe_stall)
- o_flush_decode  out  1  clear decode (drives decode i_pipe_flush)
- o_bubble_ex  out  1  load NOP into execute instead of decode output
- o_halted  out  1  core halted on decode error
- o_err_pc  out  32  PC of faulting instruction
- o_stall_count  out  16  saturating count of cycles with o_stall_decode=1

## Operation
- States: RUN, FLUSH, HALT. Registered state and a 4-bit flush counter; all control outputs are combinational from state and current inputs.
- Load-use hazard (LU): i_ex_valid && i_ex_opcode==5'h14 && i_ex_dr!=0 && i_dec_valid && (i_ex_dr==i_dec_sr1 || i_ex_dr==i_dec_sr2). r0 never matches.
- Priority in RUN, highest first:
  - i_br_taken: o_flush_decode=1, stalls=0, bubble=0. If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1.
  - i_decode_err: go to HALT, latch o_err_pc<=i_dec_pc. In this cycle o_stall_fetch=o_stall_decode=1.
  - i_mem_busy: o_stall_fetch=o_stall_decode=1, o_bubble_ex=0 (execute holds too).
  - LU: o_stall_fetch=o_stall_decode=1, o_bubble_ex=1.
  - Otherwise all controls 0.
- FLUSH:
  - o_flush_decode=1, o_stall_fetch=0. o_stall_decode=0, since flush dominates in decode.
  - i_decode_err is ignored because it comes from the wrong path.
  - Counter decrements only when !i_mem_busy. Reaching 0 returns the state to RUN.
  - i_br_taken in FLUSH reloads the counter to FLUSH_CYCLES-1.
- HALT:
  - o_halted=1, o_stall_fetch=o_stall_decode=1, o_flush_decode=0, o_bubble_ex=0.
  - All inputs are ignored. Exit only by reset.
- o_stall_count increments when o_stall_decode=1 and stops at 16'hFFFF.

## Timing
- Reset (i_reset_n=0, async): state=RUN, counter=0, o_err_pc=0, o_stall_count=0. All outputs are 0 while reset is asserted.
- Hazard response is zero latency: controls are valid in the same cycle as the triggering inputs.
- LU stall lasts exactly one cycle if no other event occurs. The bubble moves LW to memory, so LU clears next cycle and forwarding supplies the operand.
- LU with i_mem_busy: stall without bubble until !i_mem_busy. The first non-busy cycle with LU still true asserts the bubble.
- i_br_taken at cycle N: o_flush_decode=1 in cycles N..N+FLUSH_CYCLES-1, extended by any i_mem_busy cycles during FLUSH.
- i_decode_err at cycle N in RUN: o_halted=1 from N+1, and o_err_pc is valid from N+1.
- i_decode_err and i_br_taken in the same cycle: the branch wins and no halt occurs.
- Reset in FLUSH or HALT returns to RUN immediately and asynchronously.

## Test plan
- LW r3 in execute, decode has sr1=3 -> one cycle of stall_fetch/stall_decode/bubble_ex=1, then all 0. The same scenario with i_ex_dr=0 -> no stall.
- LU plus i_mem_busy held 3 cycles -> 3 cycles of stall with bubble=0, then 1 cycle with bubble=1. o_stall_count=4.
- i_br_taken pulse at cycle 10, FLUSH_CYCLES=2 -> flush in cycles 10,11 and RUN at 12. A second pulse at 11 -> flush through cycle 12.
- i_decode_err with i_dec_pc=32'h0000_0040 -> o_halted=1 next cycle, o_err_pc=32'h40, stalls stuck at 1. Asserting i_reset_n=0 mid-cycle -> outputs 0 immediately.
- i_decode_err during FLUSH, or coincident with i_br_taken -> no halt; o_halted stays 0.
- Force 70000 stall cycles -> o_stall_count saturates at 16'hFFFF.
